// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop
// serialiser that holds every bit for CLK_FREQ/BAUD_RATE clock cycles.
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 57_600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_CNT);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       mem [FIFO_DEPTH];

    logic push, pop, baud_tick, fifo_empty;

    // ready depends only on the pre-edge count, so a full FIFO rejects a write
    // even when a pop happens on the same edge.
    assign ready      = (count_q < FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign push       = data_valid && ready;
    assign baud_tick  = (baud_q == BAUD_LAST);
    assign tx         = tx_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (idx_q != 3'd7) begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide
    // which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= data;
    end
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a queue-based model expands each accepted byte
// into its expected per-cycle line waveform and predicts ready/busy/tx.
module tb_uart_tx;
    localparam int TB_CLK   = 1_000_000;
    localparam int TB_BAUD  = 90_000;
    localparam int DEPTH    = 4;
    localparam int BAUD_CNT = TB_CLK / TB_BAUD;   // 11 after truncation
    localparam int FRAME    = 10 * BAUD_CNT;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] q[$];      // bytes accepted but not yet started
    bit         wave[$];   // expected tx level for each upcoming cycle

    uart_tx #(
        .CLK_FREQ  (TB_CLK),
        .BAUD_RATE (TB_BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_valid(data_valid),
        .data      (data),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        return (wave.size() > 0) ? logic'(wave[0]) : 1'b1;
    endfunction

    // One clock edge of the reference: a frame starts whenever the line is
    // idle or in its final stop cycle and a byte is waiting; a write is
    // accepted only if the buffer held fewer than DEPTH bytes before the edge.
    task automatic model_edge(input bit dv, input logic [7:0] d);
        bit         accept;
        logic [7:0] b;
        logic       v;
        accept = dv && (q.size() < DEPTH);
        if (wave.size() <= 1 && q.size() > 0) begin
            b = q.pop_front();
            wave.delete();
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                repeat (BAUD_CNT) wave.push_back(v);
            end
        end else if (wave.size() > 0) begin
            void'(wave.pop_front());
        end
        if (accept) q.push_back(d);
    endtask

    task automatic check_outputs(input string phase);
        check({phase, "_tx"},    tx,    exp_tx());
        check({phase, "_ready"}, ready, (q.size() < DEPTH) ? 1 : 0);
        check({phase, "_busy"},  busy,  (wave.size() > 0 || q.size() > 0) ? 1 : 0);
    endtask

    task automatic cycle(input bit dv, input logic [7:0] d);
        data_valid = dv;
        data       = d;
        @(posedge clk);
        model_edge(dv, d);
        @(negedge clk);
        check_outputs("run");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic pulse_reset(input int hold_cycles);
        data_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        wave.delete();
        check("rst_async_tx", tx, 1);
        check("rst_async_ready", ready, 1);
        check("rst_async_busy", busy, 0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            check_outputs("in_rst");
        end
        reset = 1'b1;
    endtask

    initial begin
        int density;
        reset      = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("in_rst");
        end
        reset = 1'b1;
        idle(5);

        // Single 0xA5 frame.
        cycle(1'b1, 8'hA5);
        idle(FRAME + 5);

        // Six back-to-back writes: the sixth hits a full buffer.
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
        idle(6 * FRAME);

        // 0x00 then 0xFF: no idle gap between frames.
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'hFF);
        idle(2 * FRAME + 5);

        // Writer holds data_valid across several pops from a full buffer.
        for (int i = 0; i < 3 * FRAME; i++) cycle(1'b1, 8'(8'h40 + i));
        idle(6 * FRAME);

        // Reset in the middle of a data bit with two bytes still queued.
        cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'h5A);
        cycle(1'b1, 8'h99);
        idle(3 * BAUD_CNT + BAUD_CNT / 2);
        pulse_reset(3);
        idle(3 * FRAME);

        // Random traffic: sparse then dense writes, with rare reset pulses.
        for (int r = 0; r < 2500; r++) begin
            density = (r < 1200) ? 2 : 30;
            if ($urandom_range(0, 499) == 0) pulse_reset(2);
            cycle($urandom_range(0, 99) < density, 8'($urandom));
        end
        idle(6 * FRAME);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
